// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and the
// write-back stage state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic {
        RUN,
        HALTED
    } wbState_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational dstE/dstM decoder for Y86-64; the PC-update logic reuses it.
module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);

    // Unlisted and invalid icodes fall through to "no destination".
    always_comb begin
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            IRRMOVQ: begin
                if (cnd) dstE = rB;
            end
            IIRMOVQ, IOPQ: dstE = rB;
            ICALL, IRET, IPUSHQ: dstE = RRSP;
            IPOPQ: begin
                dstE = RRSP;
                dstM = rA;
            end
            IMRMOVQ: dstM = rA;
            default: ;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage with the 15-entry register file, sticky halt and
// retired counter. Define WB_FORWARD_EN to bypass same-cycle writes to reads.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    wbState_t          state;
    wbState_t          nextState;
    logic              commit;
    logic [DATA_W-1:0] regs [15];
    logic [CNT_W-1:0]  retiredCount;

    wb_dst_sel dstSel (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .dstE  (dstE),
        .dstM  (dstM)
    );

    assign commit = wb_valid && (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (commit && (icode == IHALT)) nextState = HALTED;
    end

    // The M write is issued last so it overrides E when both target one register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs[i] <= '0;
            retiredCount <= '0;
        end else if (commit) begin
            if (dstE != RNONE) regs[dstE] <= valE;
            if (dstM != RNONE) regs[dstM] <= valM;
            retiredCount <= retiredCount + CNT_ONE;
        end
    end

    always_comb begin
        rdA = (srcA == RNONE) ? '0 : regs[srcA];
        rdB = (srcB == RNONE) ? '0 : regs[srcB];
`ifdef WB_FORWARD_EN
        if (commit && (dstE != RNONE) && (dstE == srcA)) rdA = valE;
        if (commit && (dstM != RNONE) && (dstM == srcA)) rdA = valM;
        if (commit && (dstE != RNONE) && (dstE == srcB)) rdB = valE;
        if (commit && (dstM != RNONE) && (dstM == srcB)) rdB = valM;
`endif
    end

    assign halted  = (state == HALTED);
    assign retired = retiredCount;

endmodule
